// File: rtl/imem_pkg.sv
// Shared types and constants for the wait-stated instruction memory.
package imem_pkg;

  // Controller states: accept, count wait states, second fetch word, respond
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READ2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Byte offsets within a word that the controller distinguishes
  localparam logic [1:0] ALIGNED = 2'b00;
  localparam logic [1:0] HALF    = 2'b10;

  // Width of the wait-state counter; never narrower than one bit
  function automatic int ws_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

  // Width of the word index into the storage array
  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port word storage with byte write enables and a registered read.
// Contents are deliberately left out of reset so program images survive it.
module imem_array #(
  parameter int DEPTH = 262144,
  parameter int IDX_W = 18
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // One access per edge: a byte-masked write, otherwise an enabled read
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_ws.sv
// Instruction/program memory on the native valid/ready bus with programmable
// wait states, halfword-aligned 32-bit fetch and an error response for
// illegal or out-of-range accesses.
module imem_ws
  import imem_pkg::*;
#(
  parameter int MEM_SIZE        = 1048576,
  parameter int WAIT_STATES     = 0,
  parameter int ALLOW_UNALIGNED = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int              DEPTH   = MEM_SIZE / 4;
  localparam int              IDX_W   = idx_width(DEPTH);
  localparam int              WS_W    = ws_width(WAIT_STATES);
  localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);
  localparam logic [32:0]     DEPTH_X = 33'(DEPTH);
  localparam bit              ALLOW   = (ALLOW_UNALIGNED != 0);
  localparam bit              HAS_WS  = (WAIT_STATES > 0);

  state_t state_q, state_d;

  logic [WS_W-1:0]  cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             err_q;
  logic             half_q;
  logic             wr_q;
  logic [15:0]      lo_q;
  logic [31:0]      hold_q;
  logic             err_out_q;

  logic [32:0]      word_x;
  logic [32:0]      next_x;
  logic [1:0]       offset;
  logic             is_write;
  logic             is_half;
  logic             out_of_range;
  logic             req_err;
  logic             req_half;
  logic             accept;
  logic             cnt_last;

  logic             arr_en;
  logic             arr_we;
  logic [IDX_W-1:0] arr_addr;
  logic [31:0]      arr_rdata;
  logic [31:0]      resp_rdata;

  // The full address is range-checked, so upper bits are never dropped
  assign word_x       = {3'b000, mem_addr[31:2]};
  assign next_x       = word_x + 33'd1;
  assign offset       = mem_addr[1:0];
  assign is_write     = |mem_wstrb;
  assign is_half      = (offset == HALF);
  assign out_of_range = (word_x >= DEPTH_X);

  assign req_err  = mem_addr[0]
                  | out_of_range
                  | (is_write && (offset != ALIGNED))
                  | (is_half && (!ALLOW || (next_x >= DEPTH_X)));
  assign req_half = is_half & ~req_err;

  assign mem_ready = (state_q == RESP);
  assign accept    = (state_q == IDLE) && mem_valid && !mem_ready;
  assign cnt_last  = (cnt_q == WS_W'(1)) || (cnt_q == '0);

  // Next-state selection; errors never take the second-word fetch path
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (HAS_WS) begin
            state_d = WAIT;
          end else if (req_half) begin
            state_d = READ2;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_d = half_q ? READ2 : RESP;
        end
      end
      READ2: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latches, wait counter and the low fetch half
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      half_q  <= 1'b0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= mem_addr[IDX_W+1:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        err_q   <= req_err;
        half_q  <= req_half;
        wr_q    <= is_write;
        cnt_q   <= WS_LOAD;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - WS_W'(1);
      end
      if (state_q == READ2) begin
        lo_q <= arr_rdata[31:16];
      end
    end
  end

  // Array port: read word w at accept, word w+1 in READ2, write in RESP
  always_comb begin
    arr_addr = idx_q;
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    case (state_q)
      IDLE: begin
        arr_addr = mem_addr[IDX_W+1:2];
        arr_en   = accept;
      end
      READ2: begin
        arr_addr = idx_q + IDX_W'(1);
        arr_en   = 1'b1;
      end
      RESP: begin
        arr_we = resetn && wr_q && !err_q;
      end
      default: begin
        arr_en = 1'b0;
      end
    endcase
  end

  // Response data: zero for errors and writes, merged halves for a fetch
  always_comb begin
    resp_rdata = arr_rdata;
    if (err_q || wr_q) begin
      resp_rdata = '0;
    end else if (half_q) begin
      resp_rdata = {arr_rdata[15:0], lo_q};
    end
  end

  // Error flag changes with the rising ready edge; data is held afterwards
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_out_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      if ((state_d == RESP) && (state_q != RESP)) begin
        err_out_q <= (state_q == IDLE) ? req_err : err_q;
      end
      if (state_q == RESP) begin
        hold_q <= resp_rdata;
      end
    end
  end

  assign mem_err   = err_out_q;
  assign mem_rdata = mem_ready ? resp_rdata : hold_q;

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (wstrb_q),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: doc/imem_ws.md
# imem_ws

Parametrised instruction/program memory for the PicoRV32-style native memory bus, replacing the fixed single-cycle instruction memory. It adds configurable wait states, halfword-aligned 32-bit fetch for compressed-code streams, byte-strobed writes for program loading, and an error response for illegal or out-of-range accesses. It sits between the core's instruction port, or the decompressor's fetch port, and a single-port word array.

## Interface
- MEM_SIZE, 1048576: capacity in bytes; power of two, at least 8.
- WAIT_STATES, 0: extra cycles inserted before every response; legal range 0..15.
- ALLOW_UNALIGNED, 1: 1 enables halfword-aligned fetch; 0 returns an error for it.
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- mem_valid  in  1  request; held high by the master until mem_ready.
- mem_ready  out  1  one-cycle response strobe.
- mem_addr  in  32  byte address; held stable while mem_valid is high.
- mem_wdata  in  32  write data; held stable with mem_addr.
- mem_wstrb  in  4  byte-lane write enables; 0 means read.
- mem_rdata  out  32  read data; valid while mem_ready is high.
- mem_err  out  1  error flag; valid while mem_ready is high.

## Operation
- Word index is w = mem_addr[31:2], with DEPTH = MEM_SIZE/4.
- Index width is $clog2(DEPTH). The full 32-bit address is range-checked; upper bits are not truncated.
- FSM states: IDLE, WAIT, READ2, RESP.
- IDLE:
  - Accept when mem_valid=1 and mem_ready=0.
  - On accept, latch addr, wdata and wstrb, and load the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP, or READ2 for a legal unaligned fetch.
- WAIT: decrement the counter each cycle. At 0, go to READ2 for a legal unaligned fetch, otherwise RESP.
- READ2: capture the upper half of word w, then go to RESP.
- RESP: drive mem_ready=1 for exactly one cycle, then return to IDLE.
- Aligned read (addr[1:0]=0): rdata = mem[w].
- Unaligned fetch (addr[1:0]=2, ALLOW_UNALIGNED=1): rdata = {mem[w+1][15:0], mem[w][31:16]}.
  - The fetch takes two array reads, word w then word w+1.
- Write (wstrb≠0, addr[1:0]=0, in range):
  - Lane i, bits 8i+7:8i, takes wdata in the RESP cycle.
  - rdata=0 and err=0.
- Error cases:
  - w ≥ DEPTH.
  - Unaligned fetch with w+1 ≥ DEPTH.
  - addr[0]=1.
  - addr[1]=1 with ALLOW_UNALIGNED=0.
  - wstrb≠0 with addr[1:0]≠0.
- Error response: mem_err=1, mem_rdata=0, memory unchanged. It skips READ2 and keeps the aligned latency.
- Memory contents are never cleared by reset.

## Timing
- Reset values: mem_ready=0, mem_err=0, mem_rdata=0, state=IDLE, counter=0.
- Reset applied mid-transaction:
  - Aborts the transaction.
  - Suppresses mem_ready.
  - Discards any pending write.
- Cycle numbering: cycle 0 is the edge that accepts the request.
- Aligned read, write or error: mem_ready is high in cycle 1+WAIT_STATES. WAIT_STATES=0 gives one-cycle latency.
- Legal unaligned fetch: mem_ready is high in cycle 2+WAIT_STATES.
- mem_rdata and mem_err are registered. They change only on the edge that raises mem_ready and hold until the next response or reset.
- mem_valid is ignored while mem_ready=1 and in WAIT, READ2 and RESP.
- Fastest back-to-back rate: a new accept on the edge after the ready cycle. With WAIT_STATES=0 aligned, that is one access every two cycles.
- If the master drops mem_valid before ready (a protocol violation), the transaction still completes.

## Structure
- Package imem_pkg holds:
  - The state enum: IDLE, WAIT, READ2, RESP.
  - Offset constants: ALIGNED = 2'b00, HALF = 2'b10.
  - WS_W = $clog2(WAIT_STATES+1), with a minimum of 1.
- Sub-module imem_array holds the storage:
  - Single-port, DEPTH x 32, byte write-enable, registered read.
  - It holds no control logic.
- imem_ws holds the FSM, the counter, address and permission checks, and halfword merge/assembly.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x100 with wstrb=0xF, then read 0x100 -> ready one cycle after accept, rdata=0xDEADBEEF, err=0.
- WAIT_STATES=3: read 0x100 -> ready exactly 4 cycles after accept, one cycle wide. Holding valid high afterwards gives the next accept on the following edge.
- Byte lanes: preload 0x11223344, write wdata 0xAABBCCDD with wstrb=0b0101 -> readback 0x11BB33DD.
- Unaligned fetch, WAIT_STATES=1:
  - Setup: mem[0x40]=0x55667788, mem[0x44]=0x99AABBCC.
  - Read 0x42 -> rdata=0xBBCC5566, ready 3 cycles after accept.
- Errors, each -> err=1, rdata=0, memory unchanged:
  - Read at MEM_SIZE.
  - Unaligned read at MEM_SIZE-2.
  - Read at 0x101.
  - Write at 0x102.
  - ALLOW_UNALIGNED=0 read at 0x42.
- Reset: assert resetn=0 mid-WAIT on a write -> no ready, outputs 0, target word unchanged. The next read after release is correct.
